// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS core word type
package mips_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

endpackage

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - HI/LO multiply-divide unit op encoding, FSM states and word width
package muldiv_pkg;

  import mips_pkg::*;

  localparam int unsigned MULDIV_WORD_W = $bits(word_t);

  typedef enum logic [2:0] {
    OP_MUL  = 3'd0,
    OP_MULU = 3'd1,
    OP_DIV  = 3'd2,
    OP_DIVU = 3'd3,
    OP_MTHI = 3'd4,
    OP_MTLO = 3'd5
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - request/result bundle of the HI/LO unit with requester and unit modports
interface muldiv_if #(
  parameter int unsigned WIDTH = muldiv_pkg::MULDIV_WORD_W
);

  logic                   req_valid;
  logic                   req_ready;
  muldiv_pkg::muldiv_op_t req_op;
  logic [WIDTH-1:0]       req_s0;
  logic [WIDTH-1:0]       req_s1;
  logic                   flush;
  logic                   busy;
  logic                   done;
  logic                   dbz;
  logic                   err;
  logic [WIDTH-1:0]       hi;
  logic [WIDTH-1:0]       lo;

  modport master (
    output req_valid, req_op, req_s0, req_s1, flush,
    input  req_ready, busy, done, dbz, err, hi, lo
  );

  modport slave (
    input  req_valid, req_op, req_s0, req_s1, flush,
    output req_ready, busy, done, dbz, err, hi, lo
  );

endinterface

// File: rtl/muldiv_div_step.sv
// rtl/muldiv_div_step.sv - one restoring-divide step: shifted partial remainder vs divisor
module muldiv_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_q
);

  logic [WIDTH:0] w_diff;

  // The partial remainder stays below twice the divisor, so bit WIDTH of the
  // difference is the borrow of the trial subtraction.
  assign w_diff = i_rem - {1'b0, i_div};
  assign o_q    = ~w_diff[WIDTH];
  assign o_rem  = o_q ? w_diff[WIDTH-1:0] : i_rem[WIDTH-1:0];

endmodule

// File: rtl/muldiv.sv
// rtl/muldiv.sv - iterative HI/LO multiply/divide unit; MULDIV_DIV_EN enables the divider
module muldiv
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MULDIV_WORD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  muldiv_op_t       req_op,
  input  logic [WIDTH-1:0] req_s0,
  input  logic [WIDTH-1:0] req_s1,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic             err,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned        CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

  muldiv_state_t      r_state;
  muldiv_state_t      w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_p;
  logic [WIDTH-1:0]   r_b;
  logic               r_neg_res;

  logic               w_accept;
  logic               w_commit;
  logic               w_long_op;
  logic               w_move_op;
  logic               w_div_op;
  logic               w_signed;
  logic               w_neg0;
  logic               w_neg1;
  logic [WIDTH-1:0]   w_mag0;
  logic [WIDTH-1:0]   w_mag1;
  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_step;
  logic [2*WIDTH-1:0] w_p_step;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_result;
  logic               w_res_dbz;

  assign w_div_op  = (req_op == OP_DIV) | (req_op == OP_DIVU);
  assign w_move_op = (req_op == OP_MTHI) | (req_op == OP_MTLO);
  assign w_signed  = (req_op == OP_MUL) | (req_op == OP_DIV);
`ifdef MULDIV_DIV_EN
  assign w_long_op = (req_op == OP_MUL) | (req_op == OP_MULU) | w_div_op;
`else
  assign w_long_op = (req_op == OP_MUL) | (req_op == OP_MULU);
`endif

  assign w_neg0   = w_signed & req_s0[WIDTH-1];
  assign w_neg1   = w_signed & req_s1[WIDTH-1];
  assign w_mag0   = w_neg0 ? -req_s0 : req_s0;
  assign w_mag1   = w_neg1 ? -req_s1 : req_s1;
  assign w_accept = req_valid & req_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    req_ready   = 1'b0;
    busy        = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        req_ready = ~flush & ~rst;
        if (req_valid && !flush && !rst && w_long_op) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (flush)                  w_state_nxt = ST_IDLE;
        else if (r_cnt == CNT_LAST) w_state_nxt = ST_FIX;
      end
      ST_FIX: begin
        w_state_nxt = ST_IDLE;
        w_commit    = ~flush;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= (r_state == ST_RUN) ? r_cnt + CNT_ONE : '0;
    end
  end

  // Shift-add: low half holds the unconsumed multiplier bits, high half the running sum.
  assign w_addend   = r_p[0] ? r_b : '0;
  assign w_mul_sum  = {1'b0, r_p[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
  assign w_mul_step = {w_mul_sum, r_p[WIDTH-1:1]};
  assign w_prod     = r_neg_res ? -r_p : r_p;

`ifdef MULDIV_DIV_EN
  logic             r_is_div;
  logic             r_neg_rem;
  logic             r_dbz;
  logic [WIDTH-1:0] w_rem_nxt;
  logic             w_q_bit;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;

  muldiv_div_step #(.WIDTH(WIDTH)) u_div_step (
    .i_rem (r_p[2*WIDTH-1:WIDTH-1]),
    .i_div (r_b),
    .o_rem (w_rem_nxt),
    .o_q   (w_q_bit)
  );

  assign w_p_step  = r_is_div ? {w_rem_nxt, r_p[WIDTH-2:0], w_q_bit} : w_mul_step;
  // A zero divisor leaves the dividend magnitude as remainder; only the quotient is forced.
  assign w_quo     = r_dbz ? '1 : (r_neg_res ? -r_p[WIDTH-1:0] : r_p[WIDTH-1:0]);
  assign w_rem     = r_neg_rem ? -r_p[2*WIDTH-1:WIDTH] : r_p[2*WIDTH-1:WIDTH];
  assign w_result  = r_is_div ? {w_rem, w_quo} : w_prod;
  assign w_res_dbz = r_is_div & r_dbz;

  always_ff @(posedge clk) begin
    if (w_accept && w_long_op) begin
      r_is_div  <= w_div_op;
      r_neg_rem <= w_neg0;
      r_dbz     <= w_div_op & (req_s1 == '0);
    end
  end
`else
  assign w_p_step  = w_mul_step;
  assign w_result  = w_prod;
  assign w_res_dbz = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (w_accept && w_long_op) begin
      r_b       <= w_div_op ? w_mag1 : w_mag0;
      r_p       <= {{WIDTH{1'b0}}, (w_div_op ? w_mag0 : w_mag1)};
      r_neg_res <= w_neg0 ^ w_neg1;
    end else if (r_state == ST_RUN) begin
      r_p <= w_p_step;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
      dbz  <= 1'b0;
      err  <= 1'b0;
    end else begin
      done <= w_commit;
      dbz  <= w_commit & w_res_dbz;
      err  <= w_accept & ~w_long_op & ~w_move_op;
      if (w_accept && req_op == OP_MTHI) hi <= req_s0;
      if (w_accept && req_op == OP_MTLO) lo <= req_s0;
      if (w_commit) {hi, lo} <= w_result;
    end
  end

endmodule
